tt_wb_bridge_v2: RTL and testbench
==================================

Name: tt_wb_bridge_v2

Overview:
- Byte-serial command port on the TT pin set that acts as a Wishbone classic master, driven under external CPU control.
- Successor of the fixed 32-bit/14-bit-address bridge, parametrised in data and address width.
- Adds over the previous bridge: post-increment burst ops, wb_ERR handling, a sticky error flag, explicit byte-lane readback pointer, and an optional bus-timeout watchdog.
- Sits between the tt_um top pins and the project's internal Wishbone slaves.

Parameters:
- DATA_WIDTH, 32: Wishbone data width. Legal values 8, 16, 32. NB = DATA_WIDTH/8 bytes; SEL_WIDTH = NB; ALIGN = log2(NB).
- ADDRESS_WIDTH, 14: word-address width on wb_ADR. Full byte address width FA = ADDRESS_WIDTH+ALIGN, with FA ≤ 32.
- TIMEOUT_WIDTH, 8: watchdog counter width. Used only when the optional feature is compiled in.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  project enable; when low, cmd is treated as IDLE
- ui_in  in  8  command payload byte (in8)
- uo_out  out  8  readback byte
- uio_in  in  8  [7:5] = cmd; [4:0] ignored
- uio_out  out  8  [4] = done, [3] = err, all other bits 0
- uio_oe  out  8  8'b0001_1000 (constant)
- wb_CYC  out  1  cycle
- wb_STB  out  1  strobe
- wb_WE  out  1  write enable
- wb_ACK  in  1  slave acknowledge
- wb_ERR  in  1  slave error
- wb_ADR  out  ADDRESS_WIDTH  = ADR[FA-1:ALIGN]
- wb_SEL  out  SEL_WIDTH  SEL register on writes; all-ones on reads
- wb_DAT_MOSI  out  DATA_WIDTH  DO register
- wb_DAT_MISO  in  DATA_WIDTH  read data

Behaviour:
- Reset (rst_n low, async) or EXEC RESET (sync): all regs clear to 0; SEL = all-ones; state = IDLE; uo_out = 0; done = err = 0; rptr = 0.
- Commands (cmd = uio_in[7:5]): 0 IDLE, 1 EXEC, 2 ADR, 3 DAT, 4 RD, 5-7 reserved (no-op).
- Command timing: cmd_last is registered every cycle. ADR, DAT and RD act on every cycle they are present. EXEC acts only on its first cycle (cmd_last != EXEC).
- ADR: ADR <= {ADR, in8} truncated to FA bits (MSB-first shift).
- DAT: DO <= {DO, in8} truncated to DATA_WIDTH bits.
- RD: uo_out <= DI[rptr*8 +: 8]; rptr <= (rptr+1) mod NB.
- EXEC sub-op, in8[3:0]:
  - 1 RESET.
  - 2 SEL <= in8[4 +: SEL_WIDTH].
  - 4 DISABLE: cyc_hold = 0.
  - 5 ENABLE: cyc_hold = 1.
  - 6 READ; 7 WRITE.
  - 8 READ_INC; 9 WRITE_INC.
  - Others: no-op.
- FSM IDLE -> BUS: on READ/WRITE/_INC in IDLE. Same cycle: STB = 1; WE = 1 for writes; done = err = 0; timeout counter = 0.
- FSM BUS -> IDLE on any of:
  - ACK: done = 1. On read, DI <= MISO, uo_out <= MISO[7:0], rptr <= 1 (mod NB). For _INC ops, ADR <= ADR + NB, wrapping mod 2^FA.
  - ERR (wins if ACK is simultaneous): done = 1, err = 1, DI and ADR unchanged.
  - DISABLE EXEC: abort, STB = 0, done = 1, err = 1.
- In BUS: new READ/WRITE/SEL EXEC ops are ignored. ADR, DAT and RD still execute, but ADR/DO must not be changed by the host while in BUS; changing them there is undefined. wb_ADR and wb_DAT_MOSI come straight from the registers.
- wb_CYC = cyc_hold | STB, so a single transfer works without ENABLE. wb_STB = STB; WE clears when leaving BUS.
- done and err are sticky until the next launch or reset.
- Latency: STB asserts the cycle after the first EXEC cycle is sampled. done is visible the cycle after ACK.
- A zero-wait slave (ACK in the first STB cycle) completes in exactly one STB cycle.

Optional Feature:
- Macro TT_WB_BRIDGE_TIMEOUT_EN.
- Defined: in BUS, the counter increments each cycle. Reaching all-ones without ACK/ERR aborts the transfer: STB = 0, done = 1, err = 1, DI unchanged. A 255-cycle wait (width 8) completes normally.
- Undefined: no counter is built; BUS waits indefinitely for ACK/ERR/DISABLE/reset.

Test Plan:
- Defaults; ADR 0x00,0x12,0x34; DAT 0xDE,0xAD,0xBE,0xEF; EXEC 0x02 (SEL = 0x0 via in8 = 0x02?) then EXEC 0xF2 (SEL = 0xF); EXEC 0x07 -> one STB cycle with ADR = 0x048D, MOSI = 0xDEADBEEF, WE = 1, SEL = 0xF; done = 1.
- ADR 0x0040; EXEC 0x08 with slave returning 0x11223344 after 3 wait states -> uo_out = 0x44; then RD x4 -> 0x33, 0x22, 0x11, 0x44; wb_ADR advances from 0x10 to 0x11.
- EXEC READ, slave asserts ACK and ERR in the same cycle -> err = 1, done = 1, DI unchanged, ADR not incremented.
- EXEC held for 5 cycles -> exactly one transfer. EXEC released and reissued -> second transfer.
- rst_n pulsed low mid-BUS -> STB/CYC drop asynchronously; done = err = 0; SEL = 0xF.
- With TT_WB_BRIDGE_TIMEOUT_EN and a slave that never ACKs -> abort after 255 cycles with err = 1. Without the macro -> STB still high at cycle 1000; DISABLE then aborts with err = 1.

Source files
------------

// File: rtl/tt_wb_bridge_v2.sv
// Byte-serial TT pin command port acting as a Wishbone classic master.
// Optional bus watchdog: define TT_WB_BRIDGE_TIMEOUT_EN.
module tt_wb_bridge_v2 #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 14,
  parameter int TIMEOUT_WIDTH = 8,
  parameter int SEL_WIDTH     = DATA_WIDTH / 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic [7:0]               ui_in,
  output logic [7:0]               uo_out,
  input  logic [7:0]               uio_in,
  output logic [7:0]               uio_out,
  output logic [7:0]               uio_oe,
  output logic                     wb_CYC,
  output logic                     wb_STB,
  output logic                     wb_WE,
  input  logic                     wb_ACK,
  input  logic                     wb_ERR,
  output logic [ADDRESS_WIDTH-1:0] wb_ADR,
  output logic [SEL_WIDTH-1:0]     wb_SEL,
  output logic [DATA_WIDTH-1:0]    wb_DAT_MOSI,
  input  logic [DATA_WIDTH-1:0]    wb_DAT_MISO
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int ALIGN = $clog2(NB);
  localparam int FA    = ADDRESS_WIDTH + ALIGN;
  localparam int RW    = (ALIGN > 0) ? ALIGN : 1;

  typedef enum logic [2:0] {
    C_IDLE = 3'd0,
    C_EXEC = 3'd1,
    C_ADR  = 3'd2,
    C_DAT  = 3'd3,
    C_RD   = 3'd4
  } cmd_t;

  typedef enum logic [3:0] {
    OP_RESET     = 4'd1,
    OP_SEL       = 4'd2,
    OP_DISABLE   = 4'd4,
    OP_ENABLE    = 4'd5,
    OP_READ      = 4'd6,
    OP_WRITE     = 4'd7,
    OP_READ_INC  = 4'd8,
    OP_WRITE_INC = 4'd9
  } op_t;

  typedef enum logic {
    S_IDLE,
    S_BUS
  } state_t;

  state_t                  state;
  logic [2:0]              cmd;
  logic [2:0]              cmd_last;
  logic [3:0]              op;
  logic                    exec_go;
  logic                    launch;
  logic [FA-1:0]           adr_q;
  logic [DATA_WIDTH-1:0]   do_q;
  logic [DATA_WIDTH-1:0]   di_q;
  logic [SEL_WIDTH-1:0]    sel_q;
  logic [7:0]              uo_q;
  logic [RW-1:0]           rptr;
  logic                    cyc_hold;
  logic                    stb_q;
  logic                    we_q;
  logic                    inc_q;
  logic                    done_q;
  logic                    err_q;
  logic                    tmo_hit;
  logic [FA+7:0]           adr_cat;
  logic [DATA_WIDTH+7:0]   do_cat;
  logic [FA-1:0]           adr_shift;
  logic [DATA_WIDTH-1:0]   do_shift;
  logic [7:0]              rd_byte;
  logic [RW-1:0]           rptr_inc;
  logic [RW-1:0]           rptr_one;

`ifdef TT_WB_BRIDGE_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] tmo_q;
  assign tmo_hit = &tmo_q;
`else
  assign tmo_hit = 1'b0;
`endif

  assign cmd     = ena ? uio_in[7:5] : C_IDLE;
  assign op      = ui_in[3:0];
  assign exec_go = (cmd == C_EXEC) && (cmd_last != C_EXEC);

  assign launch = exec_go && (op == OP_READ  || op == OP_WRITE ||
                              op == OP_READ_INC || op == OP_WRITE_INC);

  assign adr_cat   = {adr_q, ui_in};
  assign do_cat    = {do_q, ui_in};
  assign adr_shift = adr_cat[FA-1:0];
  assign do_shift  = do_cat[DATA_WIDTH-1:0];

  assign rptr_inc = (NB > 1) ? rptr + RW'(1) : '0;
  assign rptr_one = (NB > 1) ? RW'(1) : '0;

  always_comb begin
    rd_byte = di_q[7:0];
    for (int i = 0; i < NB; i++) begin
      if (rptr == RW'(i)) rd_byte = di_q[i*8 +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cmd_last <= C_IDLE;
      adr_q    <= '0;
      do_q     <= '0;
      di_q     <= '0;
      sel_q    <= '1;
      uo_q     <= '0;
      rptr     <= '0;
      cyc_hold <= 1'b0;
      stb_q    <= 1'b0;
      we_q     <= 1'b0;
      inc_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef TT_WB_BRIDGE_TIMEOUT_EN
      tmo_q    <= '0;
`endif
    end else begin
      cmd_last <= cmd;
      if (exec_go && op == OP_RESET) begin
        state    <= S_IDLE;
        adr_q    <= '0;
        do_q     <= '0;
        di_q     <= '0;
        sel_q    <= '1;
        uo_q     <= '0;
        rptr     <= '0;
        cyc_hold <= 1'b0;
        stb_q    <= 1'b0;
        we_q     <= 1'b0;
        inc_q    <= 1'b0;
        done_q   <= 1'b0;
        err_q    <= 1'b0;
`ifdef TT_WB_BRIDGE_TIMEOUT_EN
        tmo_q    <= '0;
`endif
      end else begin
        unique case (1'b1)
          (cmd == C_ADR): adr_q <= adr_shift;
          (cmd == C_DAT): do_q  <= do_shift;
          (cmd == C_RD): begin
            uo_q <= rd_byte;
            rptr <= rptr_inc;
          end
          default: ;
        endcase

        if (exec_go && op == OP_ENABLE)  cyc_hold <= 1'b1;
        if (exec_go && op == OP_DISABLE) cyc_hold <= 1'b0;

        unique case (state)
          S_IDLE: begin
            if (exec_go && op == OP_SEL) sel_q <= ui_in[4 +: SEL_WIDTH];
            if (launch) begin
              state  <= S_BUS;
              stb_q  <= 1'b1;
              we_q   <= (op == OP_WRITE) || (op == OP_WRITE_INC);
              inc_q  <= (op == OP_READ_INC) || (op == OP_WRITE_INC);
              done_q <= 1'b0;
              err_q  <= 1'b0;
`ifdef TT_WB_BRIDGE_TIMEOUT_EN
              tmo_q  <= '0;
`endif
            end
          end
          S_BUS: begin
            // ERR outranks ACK; DISABLE and the watchdog only abort a stalled cycle
            if (wb_ERR) begin
              state  <= S_IDLE;
              stb_q  <= 1'b0;
              we_q   <= 1'b0;
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end else if (wb_ACK) begin
              state  <= S_IDLE;
              stb_q  <= 1'b0;
              we_q   <= 1'b0;
              done_q <= 1'b1;
              if (!we_q) begin
                di_q <= wb_DAT_MISO;
                uo_q <= wb_DAT_MISO[7:0];
                rptr <= rptr_one;
              end
              if (inc_q) adr_q <= adr_q + FA'(NB);
            end else if ((exec_go && op == OP_DISABLE) || tmo_hit) begin
              state  <= S_IDLE;
              stb_q  <= 1'b0;
              we_q   <= 1'b0;
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end else begin
`ifdef TT_WB_BRIDGE_TIMEOUT_EN
              tmo_q <= tmo_q + 1'b1;
`endif
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign uo_out      = uo_q;
  assign uio_out     = {3'b000, done_q, err_q, 3'b000};
  assign uio_oe      = 8'b0001_1000;
  assign wb_CYC      = cyc_hold | stb_q;
  assign wb_STB      = stb_q;
  assign wb_WE       = we_q;
  assign wb_ADR      = adr_q[FA-1:ALIGN];
  assign wb_SEL      = we_q ? sel_q : '1;
  assign wb_DAT_MOSI = do_q;

  logic unused_bits;
  assign unused_bits = ^{uio_in[4:0], ui_in};

endmodule

// File: tb/tb_tt_wb_bridge_v2.sv
// Directed bench for tt_wb_bridge_v2 at default widths.
// Timeout scenario follows TT_WB_BRIDGE_TIMEOUT_EN.
module tb_tt_wb_bridge_v2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b1;
  logic [7:0]  ui_in = 8'h00;
  logic [7:0]  uo_out;
  logic [7:0]  uio_in = 8'h00;
  logic [7:0]  uio_out;
  logic [7:0]  uio_oe;
  logic        wb_CYC;
  logic        wb_STB;
  logic        wb_WE;
  logic        wb_ACK = 1'b0;
  logic        wb_ERR = 1'b0;
  logic [13:0] wb_ADR;
  logic [3:0]  wb_SEL;
  logic [31:0] wb_DAT_MOSI;
  logic [31:0] wb_DAT_MISO = 32'h0;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] C_EXEC = 3'd1;
  localparam logic [2:0] C_ADR  = 3'd2;
  localparam logic [2:0] C_DAT  = 3'd3;
  localparam logic [2:0] C_RD   = 3'd4;

  tt_wb_bridge_v2 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .ui_in       (ui_in),
    .uo_out      (uo_out),
    .uio_in      (uio_in),
    .uio_out     (uio_out),
    .uio_oe      (uio_oe),
    .wb_CYC      (wb_CYC),
    .wb_STB      (wb_STB),
    .wb_WE       (wb_WE),
    .wb_ACK      (wb_ACK),
    .wb_ERR      (wb_ERR),
    .wb_ADR      (wb_ADR),
    .wb_SEL      (wb_SEL),
    .wb_DAT_MOSI (wb_DAT_MOSI),
    .wb_DAT_MISO (wb_DAT_MISO)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] c, input logic [7:0] b);
    uio_in = {c, 5'b0};
    ui_in  = b;
    step();
    uio_in = 8'h00;
  endtask

  task automatic exec(input logic [7:0] b);
    send(C_EXEC, b);
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (uo_out !== 8'h00) begin
      errors++; $display("FAIL rst_uo: got %h exp 00", uo_out);
    end
    checks++;
    if (uio_out !== 8'h00) begin
      errors++; $display("FAIL rst_uio_out: got %h exp 00", uio_out);
    end
    checks++;
    if (uio_oe !== 8'h18) begin
      errors++; $display("FAIL rst_oe: got %h exp 18", uio_oe);
    end
    checks++;
    if ({wb_CYC, wb_STB, wb_WE} !== 3'b000) begin
      errors++; $display("FAIL rst_ctl: got %b exp 000", {wb_CYC, wb_STB, wb_WE});
    end
    checks++;
    if (wb_ADR !== 14'h0 || wb_DAT_MOSI !== 32'h0 || wb_SEL !== 4'hF) begin
      errors++;
      $display("FAIL rst_bus: adr %h mosi %h sel %h exp 0 0 f", wb_ADR, wb_DAT_MOSI, wb_SEL);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_write();
    send(C_ADR, 8'h00);
    send(C_ADR, 8'h12);
    send(C_ADR, 8'h34);
    send(C_DAT, 8'hDE);
    send(C_DAT, 8'hAD);
    send(C_DAT, 8'hBE);
    send(C_DAT, 8'hEF);
    exec(8'h02);
    step();
    exec(8'hF2);
    step();
    exec(8'h07);
    checks++;
    if ({wb_CYC, wb_STB, wb_WE} !== 3'b111) begin
      errors++; $display("FAIL wr_ctl: got %b exp 111", {wb_CYC, wb_STB, wb_WE});
    end
    checks++;
    if (wb_ADR !== 14'h048D) begin
      errors++; $display("FAIL wr_adr: got %h exp 048d", wb_ADR);
    end
    checks++;
    if (wb_DAT_MOSI !== 32'hDEADBEEF) begin
      errors++; $display("FAIL wr_mosi: got %h exp deadbeef", wb_DAT_MOSI);
    end
    checks++;
    if (wb_SEL !== 4'hF) begin
      errors++; $display("FAIL wr_sel: got %h exp f", wb_SEL);
    end
    wb_ACK = 1'b1;
    step();
    wb_ACK = 1'b0;
    checks++;
    if ({wb_CYC, wb_STB, wb_WE} !== 3'b000) begin
      errors++; $display("FAIL wr_end_ctl: got %b exp 000", {wb_CYC, wb_STB, wb_WE});
    end
    checks++;
    if (uio_out !== 8'h10) begin
      errors++; $display("FAIL wr_done: got %h exp 10", uio_out);
    end
  endtask

  task automatic test_read_inc();
    logic [7:0] exp_rd [4];
    int stb_n;
    exp_rd = '{8'h33, 8'h22, 8'h11, 8'h44};
    send(C_ADR, 8'h00);
    send(C_ADR, 8'h40);
    checks++;
    if (wb_ADR !== 14'h0010) begin
      errors++; $display("FAIL ri_adr0: got %h exp 0010", wb_ADR);
    end
    exec(8'h08);
    wb_DAT_MISO = 32'h11223344;
    checks++;
    if (wb_STB !== 1'b1 || wb_WE !== 1'b0 || wb_SEL !== 4'hF || uio_out !== 8'h00) begin
      errors++;
      $display("FAIL ri_launch: stb %b we %b sel %h uio %h exp 1 0 f 00",
               wb_STB, wb_WE, wb_SEL, uio_out);
    end
    stb_n = 0;
    for (int i = 0; i < 3; i++) begin
      stb_n += int'(wb_STB);
      step();
    end
    stb_n += int'(wb_STB);
    wb_ACK = 1'b1;
    step();
    wb_ACK = 1'b0;
    wb_DAT_MISO = 32'h0;
    checks++;
    if (stb_n !== 4) begin
      errors++; $display("FAIL ri_stb_cycles: got %0d exp 4", stb_n);
    end
    checks++;
    if (uo_out !== 8'h44 || uio_out !== 8'h10 || wb_STB !== 1'b0) begin
      errors++;
      $display("FAIL ri_done: uo %h uio %h stb %b exp 44 10 0", uo_out, uio_out, wb_STB);
    end
    checks++;
    if (wb_ADR !== 14'h0011) begin
      errors++; $display("FAIL ri_adr_inc: got %h exp 0011", wb_ADR);
    end
    for (int i = 0; i < 4; i++) begin
      send(C_RD, 8'h00);
      checks++;
      if (uo_out !== exp_rd[i]) begin
        errors++; $display("FAIL ri_rd%0d: got %h exp %h", i, uo_out, exp_rd[i]);
      end
    end
  endtask

  task automatic test_ack_err();
    exec(8'h08);
    wb_DAT_MISO = 32'hAABBCCDD;
    checks++;
    if (uio_out !== 8'h00 || wb_STB !== 1'b1) begin
      errors++; $display("FAIL ae_launch: uio %h stb %b exp 00 1", uio_out, wb_STB);
    end
    wb_ACK = 1'b1;
    wb_ERR = 1'b1;
    step();
    wb_ACK = 1'b0;
    wb_ERR = 1'b0;
    wb_DAT_MISO = 32'h0;
    checks++;
    if (uio_out !== 8'h18 || wb_STB !== 1'b0) begin
      errors++; $display("FAIL ae_flags: uio %h stb %b exp 18 0", uio_out, wb_STB);
    end
    checks++;
    if (uo_out !== 8'h44 || wb_ADR !== 14'h0011) begin
      errors++; $display("FAIL ae_keep: uo %h adr %h exp 44 0011", uo_out, wb_ADR);
    end
    send(C_RD, 8'h00);
    checks++;
    if (uo_out !== 8'h33) begin
      errors++; $display("FAIL ae_di: got %h exp 33", uo_out);
    end
  endtask

  task automatic test_exec_hold();
    int stb_n;
    stb_n = 0;
    wb_ACK = 1'b1;
    uio_in = {C_EXEC, 5'b0};
    ui_in  = 8'h07;
    for (int i = 0; i < 5; i++) begin
      step();
      stb_n += int'(wb_STB);
    end
    uio_in = 8'h00;
    step();
    stb_n += int'(wb_STB);
    checks++;
    if (stb_n !== 1) begin
      errors++; $display("FAIL hold_one: got %0d exp 1", stb_n);
    end
    uio_in = {C_EXEC, 5'b0};
    step();
    stb_n += int'(wb_STB);
    uio_in = 8'h00;
    step();
    stb_n += int'(wb_STB);
    wb_ACK = 1'b0;
    checks++;
    if (stb_n !== 2 || uio_out !== 8'h10) begin
      errors++; $display("FAIL hold_two: cnt %0d uio %h exp 2 10", stb_n, uio_out);
    end
  endtask

  task automatic test_ena_cyc();
    ena = 1'b0;
    uio_in = {C_EXEC, 5'b0};
    ui_in  = 8'h07;
    step();
    checks++;
    if (wb_STB !== 1'b0) begin
      errors++; $display("FAIL ena_low: stb %b exp 0", wb_STB);
    end
    uio_in = 8'h00;
    step();
    ena = 1'b1;
    exec(8'h05);
    step();
    checks++;
    if (wb_CYC !== 1'b1 || wb_STB !== 1'b0) begin
      errors++; $display("FAIL cyc_en: cyc %b stb %b exp 1 0", wb_CYC, wb_STB);
    end
    exec(8'h04);
    step();
    checks++;
    if (wb_CYC !== 1'b0) begin
      errors++; $display("FAIL cyc_dis: cyc %b exp 0", wb_CYC);
    end
    exec(8'h01);
    step();
    checks++;
    if (wb_ADR !== 14'h0 || wb_DAT_MOSI !== 32'h0 || uo_out !== 8'h00 || uio_out !== 8'h00) begin
      errors++;
      $display("FAIL sync_rst: adr %h mosi %h uo %h uio %h exp all 0",
               wb_ADR, wb_DAT_MOSI, uo_out, uio_out);
    end
  endtask

  task automatic test_async_reset();
    exec(8'h32);
    step();
    send(C_DAT, 8'h5A);
    exec(8'h05);
    step();
    exec(8'h07);
    checks++;
    if (wb_SEL !== 4'h3 || wb_CYC !== 1'b1 || wb_DAT_MOSI !== 32'h5A) begin
      errors++;
      $display("FAIL ar_pre: sel %h cyc %b mosi %h exp 3 1 5a", wb_SEL, wb_CYC, wb_DAT_MOSI);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (wb_STB !== 1'b0 || wb_CYC !== 1'b0 || uio_out !== 8'h00) begin
      errors++;
      $display("FAIL ar_drop: stb %b cyc %b uio %h exp 0 0 00", wb_STB, wb_CYC, uio_out);
    end
    rst_n = 1'b1;
    step();
    exec(8'h07);
    checks++;
    if (wb_SEL !== 4'hF || wb_WE !== 1'b1 || wb_DAT_MOSI !== 32'h0) begin
      errors++;
      $display("FAIL ar_sel: sel %h we %b mosi %h exp f 1 0", wb_SEL, wb_WE, wb_DAT_MOSI);
    end
    wb_ACK = 1'b1;
    step();
    wb_ACK = 1'b0;
  endtask

  task automatic test_timeout();
    int stb_n;
    exec(8'h06);
    stb_n = 0;
`ifdef TT_WB_BRIDGE_TIMEOUT_EN
    for (int i = 0; i < 1100; i++) begin
      if (wb_STB !== 1'b1) break;
      stb_n++;
      step();
    end
    checks++;
    if (stb_n !== 256 || uio_out !== 8'h18 || uo_out !== 8'h00) begin
      errors++;
      $display("FAIL tmo_abort: stb %0d uio %h uo %h exp 256 18 00", stb_n, uio_out, uo_out);
    end
    exec(8'h06);
    wb_DAT_MISO = 32'h000000A5;
    for (int i = 0; i < 255; i++) step();
    wb_ACK = 1'b1;
    step();
    wb_ACK = 1'b0;
    checks++;
    if (uio_out !== 8'h10 || uo_out !== 8'hA5) begin
      errors++; $display("FAIL tmo_255ok: uio %h uo %h exp 10 a5", uio_out, uo_out);
    end
`else
    for (int i = 0; i < 1000; i++) begin
      stb_n += int'(wb_STB);
      step();
    end
    checks++;
    if (stb_n !== 1000 || wb_STB !== 1'b1) begin
      errors++; $display("FAIL hang_stb: cnt %0d stb %b exp 1000 1", stb_n, wb_STB);
    end
    exec(8'h04);
    checks++;
    if (wb_STB !== 1'b0 || wb_CYC !== 1'b0 || uio_out !== 8'h18) begin
      errors++;
      $display("FAIL dis_abort: stb %b cyc %b uio %h exp 0 0 18", wb_STB, wb_CYC, uio_out);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_inc();
    test_ack_err();
    test_exec_hold();
    test_ena_cyc();
    test_async_reset();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
